// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet/IPv4/UDP constants, header offsets and rx FSM states
// Purpose: field values and byte offsets (counted from the first byte after the
//   SFD) used by the UDP receive parser, plus the CRC-32 good-frame residue.
// Ports: none (package).
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [15:0] UDP_HDR_LEN    = 16'd8;

    // Offset of the byte that completes each field (or brackets a range).
    localparam logic [15:0] OFS_DST_MAC_FIRST = 16'd0;
    localparam logic [15:0] OFS_DST_MAC_END   = 16'd5;
    localparam logic [15:0] OFS_SRC_MAC_FIRST = 16'd6;
    localparam logic [15:0] OFS_SRC_MAC_END   = 16'd11;
    localparam logic [15:0] OFS_ETHERTYPE_END = 16'd13;
    localparam logic [15:0] OFS_VER_IHL       = 16'd14;
    localparam logic [15:0] OFS_FRAG_END      = 16'd21;
    localparam logic [15:0] OFS_PROTO         = 16'd23;
    localparam logic [15:0] OFS_SRC_IP_FIRST  = 16'd26;
    localparam logic [15:0] OFS_SRC_IP_END    = 16'd29;
    localparam logic [15:0] OFS_DST_IP_FIRST  = 16'd30;
    localparam logic [15:0] OFS_DST_IP_END    = 16'd33;
    localparam logic [15:0] OFS_SRC_PORT_END  = 16'd35;
    localparam logic [15:0] OFS_DST_PORT_END  = 16'd37;
    localparam logic [15:0] OFS_UDP_LEN_END   = 16'd39;
    localparam logic [15:0] OFS_HDR_END       = 16'd41;
    localparam logic [15:0] OFS_PAYLOAD_FIRST = 16'd42;

    // Register value (MSB-first view) after running data plus a correct FCS.
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        PAYLOAD,
        TRAIL,
        DROP
    } udp_rx_state_t;

endpackage

// File: rtl/eth_crc32.sv
// rtl/eth_crc32.sv - byte-wide reflected CRC-32 (poly 04C11DB7, init FFFFFFFF)
// Purpose: accumulates one byte per i_en cycle; i_init reloads the seed and
//   takes priority over i_en. No final inversion is applied.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_init       load FFFFFFFF
//   i_en         fold i_data into the register
//   i_data       input byte (LSB first on the wire)
//   o_crc        register contents bit-reversed, so a good frame reads CRC_RESIDUE
module eth_crc32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] next_crc;

    always_comb begin
        next_crc = crc_q ^ {24'h0, i_data};
        for (int i = 0; i < 8; i++) begin
            next_crc = next_crc[0] ? ((next_crc >> 1) ^ 32'hEDB88320) : (next_crc >> 1);
        end
        crc_d = crc_q;
        if (i_init) begin
            crc_d = 32'hFFFFFFFF;
        end else if (i_en) begin
            crc_d = next_crc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 32'hFFFFFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    always_comb begin
        o_crc = '0;
        for (int i = 0; i < 32; i++) begin
            o_crc[i] = crc_q[31 - i];
        end
    end

endmodule

// File: rtl/udp_recv.sv
// rtl/udp_recv.sv - GMII UDP/IPv4 receive parser with local address filtering
// Purpose: hunts preamble/SFD, checks the Ethernet II / IPv4 / UDP header against
//   the local MAC/IP/port, streams payload bytes and reports the sender.
// Option: define UDP_RECV_FCS_CHECK_EN to turn a bad FCS into o_pkt_err.
// Ports:
//   clk, rst_n            rx clock, async active-low reset
//   i_data, i_data_vl     GMII rx byte and rx_dv
//   i_local_mac/ip/port   destination filter (broadcast MAC always, port 0 = any)
//   o_data, o_data_vl     payload byte stream, o_sof on the first byte
//   o_src_mac/ip/port     sender addressing from the last accepted header
//   o_data_len            UDP payload length (UDP length - 8)
//   o_pkt_ok, o_pkt_err   one end-of-frame status pulse per accepted frame
module udp_recv
    import eth_pkg::*;
#(
    parameter logic [15:0] MAX_FRAME = 16'd1522
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_data_vl,
    input  logic [47:0] i_local_mac,
    input  logic [31:0] i_local_ip,
    input  logic [15:0] i_local_port,
    output logic [7:0]  o_data,
    output logic        o_data_vl,
    output logic        o_sof,
    output logic [47:0] o_src_mac,
    output logic [31:0] o_src_ip,
    output logic [15:0] o_src_port,
    output logic [15:0] o_data_len,
    output logic        o_pkt_ok,
    output logic        o_pkt_err
);

    udp_rx_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic        armed_q, armed_d;
    logic [7:0]  prev_q, prev_d;
    logic        match_q, match_d, bcast_q, bcast_d;
    logic [47:0] hdr_mac_q, hdr_mac_d;
    logic [31:0] hdr_ip_q, hdr_ip_d;
    logic [15:0] hdr_port_q, hdr_port_d, hdr_len_q, hdr_len_d;
    logic [7:0]  data_q, data_d;
    logic        data_vl_q, data_vl_d, sof_q, sof_d, pkt_ok_q, pkt_ok_d, pkt_err_q, pkt_err_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [15:0] src_port_q, src_port_d, data_len_q, data_len_d;

    logic        hdr_bad, fcs_bad, first_byte, mac_hit, bc_hit, ip_hit, payload_last;
    logic [15:0] field16;
    logic [47:0] mac_sh;
    logic [31:0] ip_sh;
    logic [1:0]  ip_idx;

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign field16 = {prev_q, i_data};

    // Multi-byte destination compares run byte by byte; the running result is
    // kept in match_q/bcast_q and restarted on the first byte of the field.
    assign first_byte = (cnt_q == OFS_DST_MAC_FIRST) || (cnt_q == OFS_DST_IP_FIRST);
    assign mac_sh     = i_local_mac << {cnt_q[2:0], 3'b000};
    assign ip_idx     = cnt_q[1:0] - 2'd2;
    assign ip_sh      = i_local_ip << {ip_idx, 3'b000};
    assign mac_hit    = (first_byte | match_q) & (i_data == mac_sh[47:40]);
    assign bc_hit     = (first_byte | bcast_q) & (i_data == 8'hFF);
    assign ip_hit     = (first_byte | match_q) & (i_data == ip_sh[31:24]);
    assign payload_last = ({1'b0, cnt_q} == ({1'b0, data_len_q} + 17'd41));

`ifdef UDP_RECV_FCS_CHECK_EN
    logic        crc_init, crc_en;
    logic [31:0] crc_val;

    assign crc_init = (state_q == PREAMBLE) && i_data_vl && (i_data == 8'hD5);
    assign crc_en   = i_data_vl && ((state_q == HEADER) || (state_q == PAYLOAD) || (state_q == TRAIL));

    eth_crc32 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_init (crc_init),
        .i_en   (crc_en),
        .i_data (i_data),
        .o_crc  (crc_val)
    );

    assign fcs_bad = (crc_val != CRC_RESIDUE);
`else
    assign fcs_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        armed_d    = armed_q | ~i_data_vl;
        prev_d     = i_data_vl ? i_data : prev_q;
        match_d    = match_q;
        bcast_d    = bcast_q;
        hdr_mac_d  = hdr_mac_q;
        hdr_ip_d   = hdr_ip_q;
        hdr_port_d = hdr_port_q;
        hdr_len_d  = hdr_len_q;
        data_d     = data_q;
        data_vl_d  = 1'b0;
        sof_d      = 1'b0;
        pkt_ok_d   = 1'b0;
        pkt_err_d  = 1'b0;
        src_mac_d  = src_mac_q;
        src_ip_d   = src_ip_q;
        src_port_d = src_port_q;
        data_len_d = data_len_q;
        hdr_bad    = 1'b0;

        case (state_q)
            IDLE: begin
                // armed_q blocks hunting into a frame that was already running at reset
                if (armed_q && i_data_vl && (i_data == 8'h55)) state_d = PREAMBLE;
            end
            PREAMBLE: begin
                if (!i_data_vl) begin
                    state_d = IDLE;
                end else if (i_data == 8'hD5) begin
                    state_d = HEADER;
                    cnt_d   = 16'd0;
                end else if (i_data != 8'h55) begin
                    state_d = DROP;
                end
            end
            HEADER: begin
                if (!i_data_vl) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q <= OFS_DST_MAC_END) begin
                        match_d = mac_hit;
                        bcast_d = bc_hit;
                        if ((cnt_q == OFS_DST_MAC_END) && !(mac_hit || bc_hit)) hdr_bad = 1'b1;
                    end
                    if ((cnt_q >= OFS_SRC_MAC_FIRST) && (cnt_q <= OFS_SRC_MAC_END))
                        hdr_mac_d = {hdr_mac_q[39:0], i_data};
                    if ((cnt_q == OFS_ETHERTYPE_END) && (field16 != ETHERTYPE_IPV4)) hdr_bad = 1'b1;
                    if ((cnt_q == OFS_VER_IHL) && (i_data != IPV4_VER_IHL)) hdr_bad = 1'b1;
                    // MF flag and fragment offset must both be clear; DF is don't-care
                    if ((cnt_q == OFS_FRAG_END) && ((field16 & 16'h3FFF) != 16'h0000)) hdr_bad = 1'b1;
                    if ((cnt_q == OFS_PROTO) && (i_data != IP_PROTO_UDP)) hdr_bad = 1'b1;
                    if ((cnt_q >= OFS_SRC_IP_FIRST) && (cnt_q <= OFS_SRC_IP_END))
                        hdr_ip_d = {hdr_ip_q[23:0], i_data};
                    if ((cnt_q >= OFS_DST_IP_FIRST) && (cnt_q <= OFS_DST_IP_END)) begin
                        match_d = ip_hit;
                        if ((cnt_q == OFS_DST_IP_END) && !ip_hit) hdr_bad = 1'b1;
                    end
                    if (cnt_q == OFS_SRC_PORT_END) hdr_port_d = field16;
                    if ((cnt_q == OFS_DST_PORT_END) && (i_local_port != 16'h0000) && (field16 != i_local_port))
                        hdr_bad = 1'b1;
                    if (cnt_q == OFS_UDP_LEN_END) begin
                        hdr_len_d = field16;
                        if (field16 < UDP_HDR_LEN) hdr_bad = 1'b1;
                    end

                    if (hdr_bad) begin
                        state_d = DROP;
                    end else if (cnt_q == OFS_HDR_END) begin
                        src_mac_d  = hdr_mac_q;
                        src_ip_d   = hdr_ip_q;
                        src_port_d = hdr_port_q;
                        data_len_d = hdr_len_q - UDP_HDR_LEN;
                        state_d    = (hdr_len_q == UDP_HDR_LEN) ? TRAIL : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (!i_data_vl) begin
                    pkt_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q >= MAX_FRAME) begin
                        pkt_err_d = 1'b1;
                        state_d   = DROP;
                    end else begin
                        data_d    = i_data;
                        data_vl_d = 1'b1;
                        sof_d     = (cnt_q == OFS_PAYLOAD_FIRST);
                        if (payload_last) state_d = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (!i_data_vl) begin
                    pkt_ok_d  = ~fcs_bad;
                    pkt_err_d = fcs_bad;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q >= MAX_FRAME) begin
                        pkt_err_d = 1'b1;
                        state_d   = DROP;
                    end
                end
            end
            DROP: begin
                if (!i_data_vl) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            prev_q     <= '0;
            match_q    <= 1'b0;
            bcast_q    <= 1'b0;
            hdr_mac_q  <= '0;
            hdr_ip_q   <= '0;
            hdr_port_q <= '0;
            hdr_len_q  <= '0;
            data_q     <= '0;
            data_vl_q  <= 1'b0;
            sof_q      <= 1'b0;
            pkt_ok_q   <= 1'b0;
            pkt_err_q  <= 1'b0;
            src_mac_q  <= '0;
            src_ip_q   <= '0;
            src_port_q <= '0;
            data_len_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            prev_q     <= prev_d;
            match_q    <= match_d;
            bcast_q    <= bcast_d;
            hdr_mac_q  <= hdr_mac_d;
            hdr_ip_q   <= hdr_ip_d;
            hdr_port_q <= hdr_port_d;
            hdr_len_q  <= hdr_len_d;
            data_q     <= data_d;
            data_vl_q  <= data_vl_d;
            sof_q      <= sof_d;
            pkt_ok_q   <= pkt_ok_d;
            pkt_err_q  <= pkt_err_d;
            src_mac_q  <= src_mac_d;
            src_ip_q   <= src_ip_d;
            src_port_q <= src_port_d;
            data_len_q <= data_len_d;
        end
    end

    assign o_data     = data_q;
    assign o_data_vl  = data_vl_q;
    assign o_sof      = sof_q;
    assign o_src_mac  = src_mac_q;
    assign o_src_ip   = src_ip_q;
    assign o_src_port = src_port_q;
    assign o_data_len = data_len_q;
    assign o_pkt_ok   = pkt_ok_q;
    assign o_pkt_err  = pkt_err_q;

endmodule

// File: tb/tb_udp_recv.sv
// tb/tb_udp_recv.sv - directed self-checking bench for udp_recv
module tb_udp_recv;

    localparam logic [47:0] LMAC  = 48'h0023543c471b;
    localparam logic [31:0] LIP   = 32'h0A000064;
    localparam logic [15:0] LPORT = 16'd5152;
    localparam logic [47:0] SMAC  = 48'h001122334455;
    localparam logic [31:0] SIP   = 32'h0A000002;
    localparam logic [15:0] SPORT = 16'd2179;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        i_data_vl = 1'b0;
    logic [47:0] i_local_mac = LMAC;
    logic [31:0] i_local_ip = LIP;
    logic [15:0] i_local_port = LPORT;
    logic [7:0]  o_data;
    logic        o_data_vl, o_sof, o_pkt_ok, o_pkt_err;
    logic [47:0] o_src_mac;
    logic [31:0] o_src_ip;
    logic [15:0] o_src_port, o_data_len;

    int tests = 0;
    int fails = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int bad_cnt = 0;
    int n0 = 0;
    int ok0 = 0;
    int err0 = 0;
    logic [8:0] rx_q[$];
    logic [7:0] frm[$];

    always #5 clk = ~clk;

    udp_recv dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_data       (i_data),
        .i_data_vl    (i_data_vl),
        .i_local_mac  (i_local_mac),
        .i_local_ip   (i_local_ip),
        .i_local_port (i_local_port),
        .o_data       (o_data),
        .o_data_vl    (o_data_vl),
        .o_sof        (o_sof),
        .o_src_mac    (o_src_mac),
        .o_src_ip     (o_src_ip),
        .o_src_port   (o_src_port),
        .o_data_len   (o_data_len),
        .o_pkt_ok     (o_pkt_ok),
        .o_pkt_err    (o_pkt_err)
    );

    always @(negedge clk) begin
        if (o_data_vl) rx_q.push_back({o_sof, o_data});
        if (o_pkt_ok) ok_cnt++;
        if (o_pkt_err) err_cnt++;
        if ((o_pkt_ok && o_pkt_err) || (o_sof && !o_data_vl)) bad_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_be(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
    endtask

    task automatic build(input logic [47:0] dmac, input logic [15:0] etype, input logic [15:0] frag,
                         input logic [31:0] dip, input logic [15:0] dport, input int plen,
                         input logic [15:0] ulen, input bit flip);
        logic [31:0] c;
        frm.delete();
        push_be(dmac, 6);
        push_be(SMAC, 6);
        push_be({32'h0, etype}, 2);
        push_be(48'h4500, 2);
        push_be({32'h0, ulen + 16'd20}, 2);
        push_be(48'h0001, 2);
        push_be({32'h0, frag}, 2);
        push_be(48'h4011, 2);
        push_be(48'h0, 2);
        push_be({16'h0, SIP}, 4);
        push_be({16'h0, dip}, 4);
        push_be({32'h0, SPORT}, 2);
        push_be({32'h0, dport}, 2);
        push_be({32'h0, ulen}, 2);
        push_be(48'h0, 2);
        for (int i = 0; i < plen; i++) frm.push_back(i[7:0]);
        while (frm.size() < 60) frm.push_back(8'hAA);
        c = 32'hFFFFFFFF;
        foreach (frm[i]) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c ^ {31'h0, flip};
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic snap();
        n0   = rx_q.size();
        ok0  = ok_cnt;
        err0 = err_cnt;
    endtask

    task automatic send(input int ncut, input int rst_at);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            i_data_vl = 1'b1;
            i_data    = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 0; i < ncut; i++) begin
            @(posedge clk); #1;
            i_data = frm[i];
            if (i == rst_at) begin
                #6;
                rst_n = 1'b0;
                #1;
                check("rst data_vl", {63'h0, o_data_vl}, 64'h0);
                check("rst sof", {63'h0, o_sof}, 64'h0);
                check("rst data", {56'h0, o_data}, 64'h0);
                check("rst src_mac", {16'h0, o_src_mac}, 64'h0);
                check("rst src_ip", {32'h0, o_src_ip}, 64'h0);
                check("rst len", {48'h0, o_data_len}, 64'h0);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        end
        @(posedge clk); #1;
        i_data_vl = 1'b0;
        i_data    = 8'h00;
        repeat (4) @(posedge clk);
    endtask

    task automatic expect_rx(input string tag, input int nbytes, input int nok, input int nerr);
        check({tag, " bytes"}, rx_q.size() - n0, nbytes);
        check({tag, " ok"}, ok_cnt - ok0, nok);
        check({tag, " err"}, err_cnt - err0, nerr);
        for (int i = 0; i < nbytes && n0 + i < rx_q.size(); i++)
            check({tag, " byte"}, {55'h0, rx_q[n0 + i]}, {55'h0, i == 0, i[7:0]});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset data_vl", {63'h0, o_data_vl}, 64'h0);
        check("reset sof", {63'h0, o_sof}, 64'h0);
        check("reset pulses", {62'h0, o_pkt_ok, o_pkt_err}, 64'h0);
        check("reset src_mac", {16'h0, o_src_mac}, 64'h0);
        check("reset src_ip", {32'h0, o_src_ip}, 64'h0);
        check("reset src_port", {48'h0, o_src_port}, 64'h0);
        check("reset len", {48'h0, o_data_len}, 64'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        build(LMAC, 16'h0800, 16'h4000, LIP, LPORT, 16, 16'd24, 1'b0);
        snap(); send(frm.size(), -1);
        expect_rx("basic", 16, 1, 0);
        check("basic len", {48'h0, o_data_len}, 64'd16);
        check("basic src_ip", {32'h0, o_src_ip}, {32'h0, SIP});
        check("basic src_port", {48'h0, o_src_port}, {48'h0, SPORT});
        check("basic src_mac", {16'h0, o_src_mac}, {16'h0, SMAC});

        build(LMAC, 16'h0800, 16'h4000, LIP, 16'd5153, 16, 16'd24, 1'b0);
        snap(); send(frm.size(), -1);
        expect_rx("port miss", 0, 0, 0);
        i_local_port = 16'd0;
        snap(); send(frm.size(), -1);
        expect_rx("port any", 16, 1, 0);
        i_local_port = LPORT;

        build(LMAC, 16'h0800, 16'h4000, LIP, LPORT, 4, 16'd12, 1'b0);
        snap(); send(frm.size(), -1);
        expect_rx("min frame", 4, 1, 0);
        check("min len", {48'h0, o_data_len}, 64'd4);

        build(LMAC, 16'h0800, 16'h4000, LIP, LPORT, 16, 16'd24, 1'b0);
        snap(); send(42 + 7, -1);
        expect_rx("truncated", 7, 0, 1);

        build(LMAC, 16'h0800, 16'h4000, LIP, LPORT, 16, 16'd24, 1'b1);
        snap(); send(frm.size(), -1);
`ifdef UDP_RECV_FCS_CHECK_EN
        expect_rx("bad fcs", 16, 0, 1);
`else
        expect_rx("fcs ignored", 16, 1, 0);
`endif

        build(BCAST, 16'h0806, 16'h4000, LIP, LPORT, 16, 16'd24, 1'b0);
        snap(); send(frm.size(), -1);
        expect_rx("arp", 0, 0, 0);

        build(BCAST, 16'h0800, 16'h4000, LIP, LPORT, 16, 16'd24, 1'b0);
        snap(); send(frm.size(), -1);
        expect_rx("bcast", 16, 1, 0);

        build(LMAC, 16'h0800, 16'h0000, LIP, LPORT, 0, 16'd8, 1'b0);
        snap(); send(frm.size(), -1);
        expect_rx("empty", 0, 1, 0);
        check("empty len", {48'h0, o_data_len}, 64'd0);

        build(LMAC, 16'h0800, 16'h4000, 32'h0A000065, LPORT, 16, 16'd24, 1'b0);
        snap(); send(frm.size(), -1);
        expect_rx("ip miss", 0, 0, 0);

        build(LMAC, 16'h0800, 16'h2000, LIP, LPORT, 16, 16'd24, 1'b0);
        snap(); send(frm.size(), -1);
        expect_rx("frag", 0, 0, 0);

        build(LMAC, 16'h0800, 16'h4000, LIP, LPORT, 16, 16'd24, 1'b0);
        snap(); send(20, -1);
        expect_rx("runt", 0, 0, 0);

        snap(); send(frm.size(), 47);
        expect_rx("reset mid", 5, 0, 0);
        snap(); send(frm.size(), -1);
        expect_rx("after reset", 16, 1, 0);
        check("after reset src_ip", {32'h0, o_src_ip}, {32'h0, SIP});

        build(LMAC, 16'h0800, 16'h4000, LIP, LPORT, 1500, 16'd1508, 1'b0);
        snap(); send(frm.size(), -1);
        check("long ok", ok_cnt - ok0, 64'd0);
        check("long err", err_cnt - err0, 64'd1);

        check("pulse overlap or stray sof", bad_cnt, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
